// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the TSC CPU datapath: sequences fetch/decode/exec/mem/writeback.
// Latency: JMP/WWD 2, branch/JPR/JAL 3, R-type/imm/JRL 4, SWD 4, LWD 5 cycles plus memory waits.
// Backpressure: mem_req is held until mem_ready; a watchdog moves to ERR after TIMEOUT unanswered cycles.
//
// Ports: clk/reset_n (async active-low); opcode/func_code/bcond from the IR and ALU;
// mem_ready completes the pending memory request; all other ports are datapath
// mux selects and enables, plus halt/mem_err (sticky) and num_inst (retired count).
module mc_control_fsm #(
   parameter int OPCODE_W = 4,
   parameter int FUNC_W   = 6,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 64,
   parameter int TMO_W    = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNC_W-1:0]   func_code,
   input  logic                bcond,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                i_or_d,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                alu_op,
   output logic                save_alu_out,
   output logic                pc_to_reg,
   output logic                wwd,
   output logic                halt,
   output logic                new_inst,
   output logic                mem_err,
   output logic [CNT_W-1:0]    num_inst
);

   localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_BGZ = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_BLZ = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_ADI = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_LHI = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_LWD = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_SWD = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(9);
   localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(10);
   localparam logic [OPCODE_W-1:0] OP_ALU = OPCODE_W'(15);

   localparam logic [FUNC_W-1:0] F_SHR = FUNC_W'(7);   // funcs 0..7 are plain ALU ops
   localparam logic [FUNC_W-1:0] F_JPR = FUNC_W'(25);
   localparam logic [FUNC_W-1:0] F_JRL = FUNC_W'(26);
   localparam logic [FUNC_W-1:0] F_WWD = FUNC_W'(28);
   localparam logic [FUNC_W-1:0] F_HLT = FUNC_W'(29);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
   } state_t;

   state_t state, next_state;

   // Instruction class decode
   logic is_br, is_imm, is_lhi, is_lwd, is_swd, is_jmp, is_jal;
   logic is_rtype, is_jpr, is_jrl, is_wwd, is_hlt, is_valid;

   always_comb begin
      is_br    = 1'b0;
      is_imm   = 1'b0;
      is_lhi   = 1'b0;
      is_lwd   = 1'b0;
      is_swd   = 1'b0;
      is_jmp   = 1'b0;
      is_jal   = 1'b0;
      is_rtype = 1'b0;
      is_jpr   = 1'b0;
      is_jrl   = 1'b0;
      is_wwd   = 1'b0;
      is_hlt   = 1'b0;
      case (opcode)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: is_br  = 1'b1;
         OP_ADI, OP_ORI:                 is_imm = 1'b1;
         OP_LHI:                         is_lhi = 1'b1;
         OP_LWD:                         is_lwd = 1'b1;
         OP_SWD:                         is_swd = 1'b1;
         OP_JMP:                         is_jmp = 1'b1;
         OP_JAL:                         is_jal = 1'b1;
         OP_ALU: begin
            if (func_code <= F_SHR)       is_rtype = 1'b1;
            else if (func_code == F_JPR)  is_jpr   = 1'b1;
            else if (func_code == F_JRL)  is_jrl   = 1'b1;
            else if (func_code == F_WWD)  is_wwd   = 1'b1;
            else if (func_code == F_HLT)  is_hlt   = 1'b1;
         end
         default: ;
      endcase
      is_valid = is_br | is_imm | is_lhi | is_lwd | is_swd | is_jmp | is_jal |
                 is_rtype | is_jpr | is_jrl | is_wwd | is_hlt;
   end

   // Watchdog: counts consecutive unanswered request cycles. Every entry into
   // FETCH/MEM follows a non-waiting cycle, so clearing on !waiting suffices.
   logic [TMO_W-1:0] wait_cnt;
   logic             waiting, tmo;

   assign waiting = mem_req & ~mem_ready;
   assign tmo     = (TIMEOUT != 0) && waiting && (wait_cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     wait_cnt <= '0;
      else if (waiting) wait_cnt <= wait_cnt + 1'b1;
      else              wait_cnt <= '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      num_inst <= '0;
      else if (pc_write) num_inst <= num_inst + 1'b1;
   end

   // Outputs are decoded from state (plus IR fields/handshake inputs), so an
   // async reset forcing IDLE drops every output in the same instant.
   always_comb begin
      next_state   = state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      i_or_d       = 1'b0;
      ir_write     = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      alu_op       = 1'b0;
      save_alu_out = 1'b0;
      pc_to_reg    = 1'b0;
      wwd          = 1'b0;
      halt         = 1'b0;
      new_inst     = 1'b0;
      mem_err      = 1'b0;
      case (state)
         S_IDLE: next_state = S_FETCH;
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            ir_write  = mem_ready;
            // A response on the deadline cycle still counts as success.
            if (mem_ready) next_state = S_DECODE;
            else if (tmo)  next_state = S_ERR;
         end
         S_DECODE: begin
            new_inst = 1'b1;
            if (is_jmp) begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               next_state = S_FETCH;
            end else if (is_jal) begin
               next_state = S_WB;
            end else if (is_wwd) begin
               wwd        = 1'b1;
               pc_write   = 1'b1;
               next_state = S_FETCH;
            end else if (is_hlt) begin
               next_state = S_HALT;
            end else if (!is_valid) begin
               pc_write   = 1'b1;     // unknown encodings retire as NOP
               next_state = S_FETCH;
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_src_a    = 1'b1;
            alu_op       = 1'b1;
            save_alu_out = 1'b1;
            if (is_lhi)                           alu_src_b = 2'd3;
            else if (is_imm || is_lwd || is_swd)  alu_src_b = 2'd2;
            if (is_br) begin
               pc_write   = 1'b1;
               pc_src     = bcond ? 2'd1 : 2'd0;
               next_state = S_FETCH;
            end else if (is_jpr) begin
               pc_write   = 1'b1;
               pc_src     = 2'd1;
               next_state = S_FETCH;
            end else if (is_lwd || is_swd) begin
               next_state = S_MEM;
            end else begin
               next_state = S_WB;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            mem_we  = is_swd;
            if (mem_ready) begin
               if (is_swd) begin
                  pc_write   = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WB;
               end
            end else if (tmo) begin
               next_state = S_ERR;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            mem_to_reg = is_lwd;
            pc_to_reg  = is_jal | is_jrl;
            if (is_jal)      pc_src = 2'd2;
            else if (is_jrl) pc_src = 2'd1;
            next_state = S_FETCH;
         end
         S_HALT: halt    = 1'b1;
         S_ERR:  mem_err = 1'b1;
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: random instruction stream with random memory wait states,
// per-instruction expectations derived from class/latency rules, plus halt, watchdog
// and async-reset scenarios.
module tb_mc_control_fsm;

   localparam int CNT_W = 6;

   localparam logic [3:0] BNE = 4'd0, BEQ = 4'd1, BGZ = 4'd2, BLZ = 4'd3;
   localparam logic [3:0] ADI = 4'd4, ORI = 4'd5, LHI = 4'd6, LWD = 4'd7, SWD = 4'd8;
   localparam logic [3:0] JMP = 4'd9, JAL = 4'd10, ALU = 4'd15;
   localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;

   logic             clk, reset_n;
   logic [3:0]       opcode;
   logic [5:0]       func_code;
   logic             bcond, mem_ready;
   logic             mem_req, mem_we, i_or_d, ir_write, mem_to_reg, reg_write, pc_write;
   logic [1:0]       pc_src, alu_src_b;
   logic             alu_src_a, alu_op, save_alu_out, pc_to_reg, wwd, halt, new_inst, mem_err;
   logic [CNT_W-1:0] num_inst;
   logic [18:0]      outs;

   mc_control_fsm #(.OPCODE_W(4), .FUNC_W(6), .CNT_W(CNT_W), .TIMEOUT(4), .TMO_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code), .bcond(bcond),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .save_alu_out(save_alu_out), .pc_to_reg(pc_to_reg), .wwd(wwd), .halt(halt),
      .new_inst(new_inst), .mem_err(mem_err), .num_inst(num_inst)
   );

   assign outs = {mem_req, mem_we, i_or_d, ir_write, mem_to_reg, reg_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, save_alu_out, pc_to_reg, wwd, halt, new_inst, mem_err};

   localparam logic [18:0] OUT_HALT  = 19'h00004;
   localparam logic [18:0] OUT_ERR   = 19'h00001;
   localparam logic [18:0] OUT_FETCH = 19'h40080;   // mem_req, alu_src_b = 1

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [3:0] op;
      logic [5:0] func;
      logic       bcond;
      int         fd;     // wait cycles before fetch is answered
      int         md;     // wait cycles before data access is answered
   } instr_t;

   typedef struct {
      int         lat;    // cycles from first fetch cycle to the pc_write cycle inclusive
      logic [1:0] pc_src;
      logic [9:0] flags;  // {halt,mem_err,reg_write,mem_to_reg,pc_to_reg,wwd,new_inst,mem_we,i_or_d,mem_req}
      int         mreq;   // cycles with mem_req high during the instruction
      logic [4:0] exec;   // {seen, alu_src_a, alu_op, alu_src_b} while save_alu_out
      logic [CNT_W-1:0] num_before;
   } exp_t;

   typedef enum {K_ALU, K_IMM, K_LHI, K_LWD, K_SWD, K_BR, K_JMP, K_JAL,
                 K_JPR, K_JRL, K_WWD, K_HLT, K_NOP} kind_e;

   instr_t stim_q[$];
   exp_t   exp_q[$];
   int     n_chk, n_pass, n_issued;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   function automatic kind_e kind_of(instr_t i);
      if (i.op == BNE || i.op == BEQ || i.op == BGZ || i.op == BLZ) return K_BR;
      if (i.op == ADI || i.op == ORI) return K_IMM;
      if (i.op == LHI) return K_LHI;
      if (i.op == LWD) return K_LWD;
      if (i.op == SWD) return K_SWD;
      if (i.op == JMP) return K_JMP;
      if (i.op == JAL) return K_JAL;
      if (i.op == ALU) begin
         if (i.func < 6'd8)     return K_ALU;
         if (i.func == FN_JPR)  return K_JPR;
         if (i.func == FN_JRL)  return K_JRL;
         if (i.func == FN_WWD)  return K_WWD;
         if (i.func == FN_HLT)  return K_HLT;
      end
      return K_NOP;
   endfunction

   // Reference: class-level latency and effect table.
   function automatic exp_t model(instr_t i, int nb);
      exp_t  e;
      kind_e k     = kind_of(i);
      int    fetch = i.fd + 1;
      int    mem   = i.md + 1;
      logic  rw, m2r, p2r, ww, ni, st;
      case (k)
         K_JMP, K_WWD, K_NOP:        e.lat = fetch + 1;
         K_BR, K_JPR, K_JAL:         e.lat = fetch + 2;
         K_SWD:                      e.lat = fetch + 2 + mem;
         K_LWD:                      e.lat = fetch + 3 + mem;
         default:                    e.lat = fetch + 3;
      endcase
      e.mreq = fetch + ((k == K_LWD || k == K_SWD) ? mem : 0);
      case (k)
         K_JMP, K_JAL: e.pc_src = 2'd2;
         K_BR:         e.pc_src = i.bcond ? 2'd1 : 2'd0;
         K_JPR, K_JRL: e.pc_src = 2'd1;
         default:      e.pc_src = 2'd0;
      endcase
      rw  = (k == K_ALU || k == K_IMM || k == K_LHI || k == K_LWD || k == K_JAL || k == K_JRL);
      m2r = (k == K_LWD);
      p2r = (k == K_JAL || k == K_JRL);
      ww  = (k == K_WWD);
      ni  = (k == K_JMP || k == K_WWD || k == K_NOP);
      st  = (k == K_SWD);
      e.flags = {1'b0, 1'b0, rw, m2r, p2r, ww, ni, st, st, st};
      case (k)
         K_ALU, K_BR, K_JPR, K_JRL: e.exec = 5'b11100;
         K_IMM, K_LWD, K_SWD:       e.exec = 5'b11110;
         K_LHI:                     e.exec = 5'b11111;
         default:                   e.exec = 5'b00000;
      endcase
      e.num_before = CNT_W'(nb);
      return e;
   endfunction

   function automatic instr_t mk(logic [3:0] op, logic [5:0] f, logic b, int fd, int md);
      instr_t i;
      i.op = op; i.func = f; i.bcond = b; i.fd = fd; i.md = md;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      int c = int'($urandom_range(0, 15));
      i.func  = 6'($urandom_range(0, 7));
      i.bcond = 1'($urandom_range(0, 1));
      i.fd    = int'($urandom_range(0, 3));
      i.md    = int'($urandom_range(0, 3));
      if (c <= 10) i.op = 4'(c);                     // 0..10 are BNE..JAL in encoding order
      else if (c == 12) begin
         i.op = ALU;
         case ($urandom_range(0, 2))
            0:       i.func = FN_JPR;
            1:       i.func = FN_JRL;
            default: i.func = FN_WWD;
         endcase
      end else if (c == 13) i.op = 4'($urandom_range(11, 14));
      else if (c == 14) begin
         i.op   = ALU;
         i.func = 6'($urandom_range(8, 24));
      end else i.op = ALU;
      return i;
   endfunction

   task automatic issue(input instr_t i);
      stim_q.push_back(i);
      if (kind_of(i) != K_HLT) begin
         exp_q.push_back(model(i, n_issued));
         n_issued++;
      end
   endtask

   // Memory/IR driver
   instr_t cur;
   int     acc_cnt, dly;
   logic   fetch_done;
   initial begin
      mem_ready = 1'b0; opcode = 4'd0; func_code = 6'd0; bcond = 1'b0;
      acc_cnt = 0; fetch_done = 1'b0;
      cur = mk(4'd0, 6'd0, 1'b0, 0, 0);
      forever begin
         @(negedge clk);
         if (!reset_n || !mem_req) begin
            mem_ready = 1'b0;
            acc_cnt   = 0;
            if (!reset_n) fetch_done = 1'b0;
         end else begin
            if (i_or_d) dly = cur.md;
            else        dly = (stim_q.size() != 0) ? stim_q[0].fd : 1000;
            if (acc_cnt == dly) begin
               mem_ready = 1'b1;
               acc_cnt   = 0;
               if (!i_or_d) begin
                  cur        = stim_q.pop_front();
                  fetch_done = 1'b1;
               end
            end else begin
               mem_ready = 1'b0;
               acc_cnt++;
            end
         end
         @(posedge clk);
         #1;
         if (fetch_done && reset_n) begin
            opcode = cur.op; func_code = cur.func; bcond = cur.bcond;
         end
         fetch_done = 1'b0;
      end
   end

   // Monitor: accumulate per-instruction observations, check at each pc_write
   logic       started;
   int         m_lat, m_mreq, m_irw, m_ni;
   logic [4:0] m_exec;
   logic [3:0] m_fetch;
   exp_t       e;
   initial begin
      started = 1'b0; m_lat = 0; m_mreq = 0; m_irw = 0; m_ni = 0; m_exec = '0; m_fetch = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!reset_n) begin
            started = 1'b0; m_lat = 0; m_mreq = 0; m_irw = 0; m_ni = 0; m_exec = '0; m_fetch = '0;
         end else begin
            if (mem_req) started = 1'b1;
            if (started) begin
               m_lat++;
               if (mem_req) m_mreq++;
               if (ir_write) begin
                  m_irw++;
                  m_fetch = {i_or_d, alu_src_a, alu_src_b, alu_op};
               end
               if (new_inst) m_ni++;
               if (save_alu_out) m_exec = {1'b1, alu_src_a, alu_op, alu_src_b};
               if (pc_write) begin
                  if (exp_q.size() == 0) chk("unexpected_pc_write", 32'(pc_write), 32'd0);
                  else begin
                     e = exp_q.pop_front();
                     chk("latency",    32'(m_lat), 32'(e.lat));
                     chk("pc_src",     32'(pc_src), 32'(e.pc_src));
                     chk("retire_flags", 32'({halt, mem_err, reg_write, mem_to_reg, pc_to_reg,
                                              wwd, new_inst, mem_we, i_or_d, mem_req}), 32'(e.flags));
                     chk("mem_req_cycles", 32'(m_mreq), 32'(e.mreq));
                     chk("ir_write_pulses", 32'(m_irw), 32'd1);
                     chk("new_inst_pulses", 32'(m_ni), 32'd1);
                     chk("exec_selects", 32'(m_exec), 32'(e.exec));
                     chk("fetch_selects", 32'(m_fetch), 32'h2);
                     chk("num_inst", 32'(num_inst), 32'(e.num_before));
                  end
                  m_lat = 0; m_mreq = 0; m_irw = 0; m_ni = 0; m_exec = '0; m_fetch = '0;
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      stim_q.delete();
      exp_q.delete();
      n_issued = 0;
      repeat (2) @(negedge clk);
      #2;
      chk("reset_outputs", 32'(outs), 32'd0);
      chk("reset_num_inst", 32'(num_inst), 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic wait_out(input int which, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         #2;
         if (which == 0 && exp_q.size() == 0) break;
         if (which == 1 && halt) break;
         if (which == 2 && mem_err) break;
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_issued = 0;
      reset_n = 1'b0;

      // Program: directed opening, random body, terminating HLT
      do_reset();
      issue(mk(ADI, 6'd0, 1'b0, 0, 0));
      issue(mk(LWD, 6'd0, 1'b0, 3, 3));
      issue(mk(BEQ, 6'd0, 1'b1, 0, 0));
      issue(mk(BNE, 6'd0, 1'b0, 0, 0));
      issue(mk(JAL, 6'd0, 1'b0, 0, 0));
      repeat (70) issue(rand_instr());
      issue(mk(ALU, FN_HLT, 1'b0, 1, 0));
      release_reset();
      wait_out(0, 3000);
      chk("drain_remaining", 32'(exp_q.size()), 32'd0);
      wait_out(1, 20);
      chk("halt_outputs", 32'(outs), 32'(OUT_HALT));
      repeat (12) @(negedge clk);
      #2;
      chk("halt_sticky", 32'(outs), 32'(OUT_HALT));
      chk("halt_num_inst", 32'(num_inst), 32'(CNT_W'(n_issued)));

      // Fetch never answered
      do_reset();
      stim_q.push_back(mk(ADI, 6'd0, 1'b0, 15, 0));
      release_reset();
      wait_out(2, 20);
      chk("fetch_tmo_outputs", 32'(outs), 32'(OUT_ERR));
      chk("fetch_tmo_req_cycles", 32'(m_mreq), 32'd4);
      repeat (10) @(negedge clk);
      #2;
      chk("err_sticky", 32'(outs), 32'(OUT_ERR));
      chk("err_num_inst", 32'(num_inst), 32'd0);

      // Data access never answered
      do_reset();
      stim_q.push_back(mk(LWD, 6'd0, 1'b0, 0, 15));
      release_reset();
      wait_out(2, 20);
      chk("mem_tmo_outputs", 32'(outs), 32'(OUT_ERR));
      chk("mem_tmo_req_cycles", 32'(m_mreq), 32'd5);

      // Async reset in the middle of a store
      do_reset();
      issue(mk(JMP, 6'd0, 1'b0, 0, 0));
      issue(mk(ADI, 6'd0, 1'b0, 1, 0));
      stim_q.push_back(mk(SWD, 6'd0, 1'b0, 0, 15));
      release_reset();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #3;
         if (mem_we) break;
      end
      chk("swd_mem_we_seen", 32'(mem_we), 32'd1);
      chk("pre_reset_num_inst", 32'(num_inst), 32'd2);
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'(outs), 32'd0);
      chk("async_reset_num_inst", 32'(num_inst), 32'd0);
      stim_q.delete();
      exp_q.delete();
      release_reset();
      #1;
      chk("post_reset_idle", 32'(outs), 32'd0);
      @(posedge clk);
      #1;
      chk("post_reset_fetch", 32'(outs), 32'(OUT_FETCH));
      chk("post_reset_num_inst", 32'(num_inst), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
